// File: rtl/noc_pkg.sv
// Shared NoC defaults: flit width and per-port VC geometry, also used by the
// upstream output-port credit counters.
package noc_pkg;

    localparam int unsigned NOC_FLIT_W   = 8;
    localparam int unsigned NOC_NUM_VC   = 2;
    localparam int unsigned NOC_VC_DEPTH = 4;

    typedef logic [NOC_FLIT_W-1:0] flit_t;

endpackage

// File: rtl/vc_fifo.sv
// Single-channel first-word-fall-through FIFO with occupancy count.
// Push is dropped when full, pop is ignored when empty; both are ignored in reset.
module vc_fifo
    import noc_pkg::*;
#(
    parameter  int unsigned W     = NOC_FLIT_W,
    parameter  int unsigned DEPTH = NOC_VC_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full && !rst;
    assign pop_ok  = pop && !empty && !rst;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers are exactly log2(DEPTH) wide, so increments wrap on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vc_buffer.sv
// Router input-port virtual-channel buffer: NUM_VC FWFT FIFOs steered by a VC
// tag, per-VC credit return pulses and a sticky protocol-error flag.
module vc_buffer
    import noc_pkg::*;
#(
    parameter  int unsigned FLIT_W = NOC_FLIT_W,
    parameter  int unsigned NUM_VC = NOC_NUM_VC,
    parameter  int unsigned DEPTH  = NOC_VC_DEPTH,
    localparam int unsigned VC_W   = $clog2(NUM_VC),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [VC_W-1:0]          in_vc,
    input  logic [FLIT_W-1:0]        in_flit,
    output logic [NUM_VC-1:0]        in_ready,
    output logic [NUM_VC*FLIT_W-1:0] out_flit,
    output logic [NUM_VC-1:0]        out_valid,
    input  logic [NUM_VC-1:0]        out_pop,
    output logic [NUM_VC-1:0]        credit_out,
    output logic [NUM_VC*CNT_W-1:0]  vc_count,
    output logic                     err
);

    logic [NUM_VC-1:0] vc_sel;
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] pop;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] credit_q, credit_d;
    logic              err_q, err_d;
    logic              bad_vc;
    logic              full_push;
    logic              empty_pop;

    assign in_ready   = ~full & {NUM_VC{!rst}};
    assign out_valid  = ~empty;
    assign credit_out = credit_q;
    assign err        = err_q;

    // An out-of-range tag matches no VC, which is how it is detected.
    always_comb begin
        vc_sel = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            vc_sel[i] = in_valid && (in_vc == VC_W'(i));
        end
        push      = vc_sel & in_ready;
        pop       = out_pop & out_valid;
        bad_vc    = in_valid && !(|vc_sel);
        full_push = |(vc_sel & full);
        empty_pop = |(out_pop & empty);
        credit_d  = pop;
        err_d     = err_q | bad_vc | full_push | empty_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= '0;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_VC; i++) begin : gen_vc
        vc_fifo #(
            .W     (FLIT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (in_flit),
            .dout  (out_flit[i*FLIT_W +: FLIT_W]),
            .count (vc_count[i*CNT_W +: CNT_W]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

endmodule

// File: tb/tb_vc_buffer.sv
// Directed bench for vc_buffer at FLIT_W=8, NUM_VC=2, DEPTH=4.
module tb_vc_buffer;

    localparam int unsigned FLIT_W = 8;
    localparam int unsigned NUM_VC = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic [0:0]               in_vc;
    logic [FLIT_W-1:0]        in_flit;
    logic [NUM_VC-1:0]        in_ready;
    logic [NUM_VC*FLIT_W-1:0] out_flit;
    logic [NUM_VC-1:0]        out_valid;
    logic [NUM_VC-1:0]        out_pop;
    logic [NUM_VC-1:0]        credit_out;
    logic [NUM_VC*CNT_W-1:0]  vc_count;
    logic                     err;

    int checks   = 0;
    int failures = 0;

    vc_buffer #(.FLIT_W(FLIT_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_vc      (in_vc),
        .in_flit    (in_flit),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_pop    (out_pop),
        .credit_out (credit_out),
        .vc_count   (vc_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] flit0();
        return out_flit[7:0];
    endfunction
    function automatic logic [7:0] flit1();
        return out_flit[15:8];
    endfunction
    function automatic logic [2:0] cnt0();
        return vc_count[2:0];
    endfunction
    function automatic logic [2:0] cnt1();
        return vc_count[5:3];
    endfunction

    initial begin
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        rst = 1'b1; in_valid = 1'b0; in_vc = 1'b0; in_flit = '0; out_pop = '0;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_vc_count", 32'(vc_count), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_credit", 32'(credit_out), 32'h0);

        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'h3);
        step();
        chk("idle_out_valid", 32'(out_valid), 32'h0);
        chk("idle_vc_count", 32'(vc_count), 32'h0);
        chk("idle_credit", 32'(credit_out), 32'h0);

        // Fill VC0 to capacity
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_vc = 1'b0; in_flit = fill[k];
            step();
            chk("fill_cnt0", 32'(cnt0()), 32'(k + 1));
            chk("fill_head0", 32'(flit0()), 32'h11);
        end
        chk("full_in_ready", 32'(in_ready), 32'h2);
        chk("full_out_valid", 32'(out_valid), 32'h1);
        chk("full_err", 32'(err), 32'h0);

        in_flit = 8'h55;
        step();
        in_valid = 1'b0;
        chk("overflow_cnt0", 32'(cnt0()), 32'h4);
        chk("overflow_err", 32'(err), 32'h1);
        chk("overflow_head0", 32'(flit0()), 32'h11);

        // Drain VC0 with out_pop[0] held
        out_pop = 2'b01;
        for (int k = 0; k < 4; k++) begin
            chk("drain_head0", 32'(flit0()), 32'(fill[k]));
            step();
            chk("drain_credit", 32'(credit_out), 32'h1);
            chk("drain_cnt0", 32'(cnt0()), 32'(3 - k));
        end
        out_pop = 2'b00;
        chk("drain_valid_end", 32'(out_valid), 32'h0);
        step();
        chk("drain_credit_end", 32'(credit_out), 32'h0);
        chk("err_sticky", 32'(err), 32'h1);

        // Wrap with simultaneous push/pop on VC1
        in_valid = 1'b1; in_vc = 1'b1; in_flit = 8'hB0;
        step();
        in_flit = 8'hB1;
        step();
        chk("wrap_pre_cnt1", 32'(cnt1()), 32'h2);
        out_pop = 2'b10;
        for (int k = 0; k < 10; k++) begin
            in_flit = 8'(8'hB2 + k);
            chk("wrap_head1", 32'(flit1()), 32'(8'hB0 + k));
            step();
            chk("wrap_cnt1", 32'(cnt1()), 32'h2);
            chk("wrap_credit", 32'(credit_out), 32'h2);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("wrap_tail1", 32'(flit1()), 32'(8'hBA + k));
            step();
        end
        out_pop = 2'b00;
        chk("wrap_empty", 32'(out_valid), 32'h0);
        step();
        chk("wrap_credit_end", 32'(credit_out), 32'h0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("clear_err", 32'(err), 32'h0);

        // Interleaved VCs
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_vc = 1'(k % 2); in_flit = 8'(8'hA0 + k);
            step();
        end
        in_valid = 1'b0;
        chk("inter_cnt0", 32'(cnt0()), 32'h4);
        chk("inter_cnt1", 32'(cnt1()), 32'h4);
        chk("inter_err", 32'(err), 32'h0);
        out_pop = 2'b11;
        for (int k = 0; k < 4; k++) begin
            chk("inter_head0", 32'(flit0()), 32'(8'hA0 + 2 * k));
            chk("inter_head1", 32'(flit1()), 32'(8'hA1 + 2 * k));
            step();
            chk("inter_credit", 32'(credit_out), 32'h3);
        end
        out_pop = 2'b10;
        step();
        out_pop = 2'b00;
        chk("empty_pop_err", 32'(err), 32'h1);
        chk("empty_pop_cnt", 32'(vc_count), 32'h0);
        chk("empty_pop_credit", 32'(credit_out), 32'h0);

        // No full-bypass: push to full VC0 while it pops
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_vc = 1'b0; in_flit = 8'(8'hD0 + k);
            step();
        end
        in_flit = 8'hD4; out_pop = 2'b01;
        step();
        in_valid = 1'b0; out_pop = 2'b00;
        chk("nobypass_cnt0", 32'(cnt0()), 32'h3);
        chk("nobypass_credit", 32'(credit_out), 32'h1);
        chk("nobypass_head0", 32'(flit0()), 32'hD1);
        chk("nobypass_err", 32'(err), 32'h1);

        // Mid-operation reset with push and pop pending
        rst = 1'b1; in_valid = 1'b1; in_vc = 1'b0; in_flit = 8'hC3; out_pop = 2'b01;
        step();
        chk("midrst_cnt", 32'(vc_count), 32'h0);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_credit", 32'(credit_out), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0; in_valid = 1'b0; out_pop = 2'b00;
        step();
        chk("postrst_cnt", 32'(vc_count), 32'h0);
        chk("postrst_credit", 32'(credit_out), 32'h0);
        chk("postrst_valid", 32'(out_valid), 32'h0);
        chk("postrst_in_ready", 32'(in_ready), 32'h3);
        chk("postrst_err", 32'(err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
